pdm_decimator: RTL and testbench

- Receive end of the 1-bit sigma-delta audio stream produced by the synth's `out` pin.
- Recovers 16-bit unsigned PCM samples (0x8000 = zero level) at clk48/2^DECIM_LOG2 using an ORDER-stage CIC decimator.
- Used on-chip as loopback monitor and in benches to check the synth's sample stream end-to-end.

---
 rtl/pdm_decimator.sv | 134 +++++++++++++
 tb/tb_pdm_decimator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// pdm_decimator: CIC decimator that turns a 1-bit sigma-delta stream back
// into 16-bit unsigned PCM (0x8000 = zero level), one sample every
// 2^DECIM_LOG2 clocks of clk48.
//
// Output protocol: sample_valid is a one-cycle strobe with no back-pressure.
// sample_out changes only on the cycle sample_valid is high and is held
// otherwise.
//
// Optional build macro PDM_SYNC2_EN: pdm_in and sync pass through a two-flop
// synchronizer first, for a pin-driven source. All timing moves by 2 clocks.
module pdm_decimator #(
  parameter int ORDER      = 2,
  parameter int DECIM_LOG2 = 10
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        pdm_in,
  input  logic        sync,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        primed
);

  // Full CIC gain is 2^(ORDER*DECIM_LOG2); one extra bit holds the top value.
  localparam int W     = ORDER * DECIM_LOG2 + 1;
  localparam int SHIFT = W - 1 - 16;
  localparam int PW    = $clog2(ORDER + 1);

  logic pdm_use;
  logic sync_use;

`ifdef PDM_SYNC2_EN
  logic [1:0] pdm_sync_q;
  logic [1:0] sync_sync_q;

  // Two-flop synchronizer for the external bitstream and its realign pulse.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      pdm_sync_q  <= 2'b00;
      sync_sync_q <= 2'b00;
    end else begin
      pdm_sync_q  <= {pdm_sync_q[0], pdm_in};
      sync_sync_q <= {sync_sync_q[0], sync};
    end
  end

  assign pdm_use  = pdm_sync_q[1];
  assign sync_use = sync_sync_q[1];
`else
  assign pdm_use  = pdm_in;
  assign sync_use = sync;
`endif

  logic [W-1:0]          integ_q [ORDER];
  logic [W-1:0]          integ_d [ORDER];
  logic [W-1:0]          delay_q [ORDER];
  logic [W-1:0]          delay_d [ORDER];
  logic [W-1:0]          comb_y;
  logic [DECIM_LOG2-1:0] phase_q;
  logic [PW-1:0]         prime_q;
  logic [15:0]           sample_q;
  logic                  valid_q;
  logic                  primed_q;

  logic                  window_end;
  logic [16:0]           c_shift;
  logic [15:0]           sample_d;

  // Integrators cascade within the cycle; the comb chain sees this edge's
  // updated last integrator. Arithmetic wraps modulo 2^W by design.
  always_comb begin
    integ_d[0] = integ_q[0] + W'(pdm_use);
    for (int k = 1; k < ORDER; k++) begin
      integ_d[k] = integ_q[k] + integ_d[k-1];
    end
    comb_y = integ_d[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      delay_d[k] = comb_y;
      comb_y     = comb_y - delay_q[k];
    end
  end

  assign window_end = &phase_q;
  // Comb output spans 0..2^(W-1); only the full-scale value overflows 16 bits.
  assign c_shift    = comb_y[W-1:SHIFT];
  assign sample_d   = c_shift[16] ? 16'hFFFF : c_shift[15:0];

  // Decimator state: integrate every edge, comb and emit at window end,
  // sync clears everything except the held sample.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        delay_q[k] <= '0;
      end
      phase_q  <= '0;
      prime_q  <= '0;
      sample_q <= 16'h0000;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else if (sync_use) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        delay_q[k] <= '0;
      end
      phase_q  <= '0;
      prime_q  <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      phase_q <= phase_q + DECIM_LOG2'(1);
      integ_q <= integ_d;
      valid_q <= 1'b0;
      if (window_end) begin
        delay_q <= delay_d;
        if (prime_q != PW'(ORDER)) begin
          prime_q <= prime_q + PW'(1);
        end
        // Output starts with the ORDER-th window; earlier ones only fill
        // the comb delays.
        if (prime_q >= PW'(ORDER - 1)) begin
          sample_q <= sample_d;
          valid_q  <= 1'b1;
          primed_q <= 1'b1;
        end
      end
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign primed       = primed_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: directed test of pdm_decimator (ORDER=2, DECIM_LOG2=10).
// Inputs change on the falling edge, outputs are sampled 1 ns after the
// rising edge. Expected values are worked out by hand from the CIC maths:
// full scale is 2^20, shifted down by 4 to 16 bits.
module tb_pdm_decimator;

  logic        clk48;
  logic        rst_n;
  logic        pdm_in;
  logic        sync;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        primed;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;

  // Stimulus source: 0 zeros, 1 ones, 2 alternating, 3 first-order encoder.
  int          mode     = 0;
  logic        sync_req = 1'b0;
  logic        alt_bit  = 1'b0;
  logic [15:0] enc_acc  = 16'h0000;
  logic [15:0] enc_val  = 16'h4000;

  pdm_decimator #(.ORDER(2), .DECIM_LOG2(10)) dut (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .pdm_in       (pdm_in),
    .sync         (sync),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .primed       (primed)
  );

  // Clock: about 48 MHz.
  initial clk48 = 1'b0;
  always #10 clk48 = ~clk48;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Entered on a falling edge: drive one bit, take the rising edge,
  // sample, and return on the next falling edge. Counts valid strobes.
  task automatic step(input int n);
    logic [16:0] sum;
    for (int i = 0; i < n; i++) begin
      sync = sync_req;
      if (sync_req) begin
        enc_acc = 16'h0000;
        alt_bit = 1'b0;
        pdm_in  = 1'b0;
      end else begin
        case (mode)
          0: pdm_in = 1'b0;
          1: pdm_in = 1'b1;
          2: begin
            alt_bit = ~alt_bit;
            pdm_in  = alt_bit;
          end
          default: begin
            sum     = {1'b0, enc_acc} + {1'b0, enc_val};
            enc_acc = sum[15:0];
            pdm_in  = sum[16];
          end
        endcase
      end
      @(posedge clk48);
      #1;
      if (sample_valid) vcnt++;
      @(negedge clk48);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pdm_in = 1'b0;
    sync   = 1'b0;
    repeat (3) @(posedge clk48);
    #1;
    check("rst_sample", 32'(sample_out), 32'h0000);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_primed", 32'(primed), 32'h0);

    // All zeros: first valid on edge 2048, none at 1024.
    @(negedge clk48);
    rst_n = 1'b1;
    mode  = 0;
    vcnt  = 0;
    step(1024);
    check("zero_no_valid_1024", 32'(vcnt), 32'h0);
    check("zero_not_primed_1024", 32'(primed), 32'h0);
    step(1023);
    check("zero_no_valid_2047", 32'(vcnt), 32'h0);
    step(1);
    check("zero_valid_2048", 32'(sample_valid), 32'h1);
    check("zero_sample", 32'(sample_out), 32'h0000);
    check("zero_primed", 32'(primed), 32'h1);

    // Alternating bits after a sync: 0x8000, valids exactly 1024 apart.
    sync_req = 1'b1;
    step(1);
    sync_req = 1'b0;
    check("alt_sync_unprimed", 32'(primed), 32'h0);
    mode = 2;
    vcnt = 0;
    step(2047);
    check("alt_no_early_valid", 32'(vcnt), 32'h0);
    step(1);
    check("alt_valid1", 32'(sample_valid), 32'h1);
    check("alt_sample1", 32'(sample_out), 32'h8000);
    vcnt = 0;
    step(1023);
    check("alt_gap_no_valid", 32'(vcnt), 32'h0);
    check("alt_gap_hold", 32'(sample_out), 32'h8000);
    step(1);
    check("alt_valid2", 32'(sample_valid), 32'h1);
    check("alt_sample2", 32'(sample_out), 32'h8000);

    // Sync mid-window, then all ones: held sample, no valid for 2048 clocks,
    // then saturated full scale.
    step(300);
    sync_req = 1'b1;
    step(1);
    sync_req = 1'b0;
    check("sync_mid_unprimed", 32'(primed), 32'h0);
    check("sync_mid_no_valid", 32'(sample_valid), 32'h0);
    mode = 1;
    vcnt = 0;
    step(2047);
    check("ones_no_early_valid", 32'(vcnt), 32'h0);
    check("ones_hold_old", 32'(sample_out), 32'h8000);
    check("ones_still_unprimed", 32'(primed), 32'h0);
    step(1);
    check("ones_valid", 32'(sample_valid), 32'h1);
    check("ones_saturate", 32'(sample_out), 32'hFFFF);

    // Sync on the window-end edge suppresses that output.
    vcnt = 0;
    step(1023);
    check("winend_pre_no_valid", 32'(vcnt), 32'h0);
    sync_req = 1'b1;
    step(1);
    sync_req = 1'b0;
    check("winend_sync_no_valid", 32'(sample_valid), 32'h0);
    check("winend_sync_unprimed", 32'(primed), 32'h0);
    check("winend_sync_hold", 32'(sample_out), 32'hFFFF);

    // Encoder at constant 0x4000, aligned by that sync.
    mode = 3;
    vcnt = 0;
    step(2047);
    check("enc_no_early_valid", 32'(vcnt), 32'h0);
    step(1);
    check("enc_valid", 32'(sample_valid), 32'h1);
    total++;
    assert (sample_out >= 16'h3FFF && sample_out <= 16'h4000) else begin
      bad++;
      $error("FAIL enc_range: observed %0h expected 3fff..4000", sample_out);
    end

    // Async reset at phase 500, held for one clock.
    step(500);
    rst_n = 1'b0;
    #1;
    check("arst_sample", 32'(sample_out), 32'h0000);
    check("arst_valid", 32'(sample_valid), 32'h0);
    check("arst_primed", 32'(primed), 32'h0);
    @(posedge clk48);
    @(negedge clk48);
    rst_n = 1'b1;
    mode  = 1;
    vcnt  = 0;
    step(2047);
    check("arst_no_early_valid", 32'(vcnt), 32'h0);
    check("arst_unprimed", 32'(primed), 32'h0);
    step(1);
    check("arst_valid_2048", 32'(sample_valid), 32'h1);
    check("arst_sample_ones", 32'(sample_out), 32'hFFFF);

    // Sync held for several clocks keeps the block cleared.
    sync_req = 1'b1;
    step(5);
    sync_req = 1'b0;
    vcnt = 0;
    step(2047);
    check("hold_sync_no_early_valid", 32'(vcnt), 32'h0);
    step(1);
    check("hold_sync_valid", 32'(sample_valid), 32'h1);
    check("hold_sync_sample", 32'(sample_out), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
